// File: rtl/mul_issue_ctrl.sv
// Issue/writeback sequencer for the 5-stage pipelined 64-bit multiplier.
// Tracks rd/tag next to the multiplier stages and buffers results behind credits.
module mul_issue_ctrl #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 6,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [63:0]      req_opr_a_i,
  input  logic [63:0]      req_opr_b_i,
  input  logic [3:0]       req_func_i,
  input  logic             req_word_i,
  input  logic [4:0]       req_rd_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic [63:0]      mul_opr_a_o,
  output logic [63:0]      mul_opr_b_o,
  output logic             mul_instr_o,
  output logic [3:0]       mul_func_o,
  output logic             mul_word_o,
  output logic             mul_kill_o,
  output logic             mul_flush_o,
  input  logic [63:0]      mul_res_i,
  input  logic             mul_valid_i,
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output logic [63:0]      wb_data_o,
  output logic [4:0]       wb_rd_o,
  output logic [TAG_W-1:0] wb_tag_o,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  output logic             hazard_o,
  output logic             idle_o,
  output logic             err_o
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LAST  = MUL_LAT - 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);

  logic [CNT_W-1:0] used_q, used_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             issue, push, pop;
  logic             flush_mask_q, err_q;

  logic             sh_v_q   [MUL_LAT];
  logic [4:0]       sh_rd_q  [MUL_LAT];
  logic [TAG_W-1:0] sh_tag_q [MUL_LAT];

  logic [63:0]      fifo_data_q [DEPTH];
  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [TAG_W-1:0] fifo_tag_q  [DEPTH];
  logic             fifo_live   [DEPTH];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  function automatic logic rd_hit(input logic [4:0] rd, input logic [4:0] a,
                                  input logic [4:0] b);
    return (rd != 5'd0) && ((rd == a) || (rd == b));
  endfunction

  // Handshakes (req_*, wb_*): a transfer occurs on a rising edge where valid
  // and ready are both high; flush_i withdraws both ready and valid that cycle.
  assign req_ready_o = (used_q < DEPTH_C) && !flush_i;
  assign issue       = req_valid_i && req_ready_o;

  assign mul_instr_o = issue;
  assign mul_opr_a_o = req_opr_a_i;
  assign mul_opr_b_o = req_opr_b_i;
  assign mul_func_o  = req_func_i;
  assign mul_word_o  = req_word_i;
  assign mul_kill_o  = flush_i;
  assign mul_flush_o = flush_i;

  assign wb_valid_o = (count_q != '0) && !flush_i;
  assign pop        = wb_valid_o && wb_ready_i;
  assign push       = sh_v_q[LAST] && !flush_i;
  assign wb_data_o  = fifo_data_q[rd_ptr_q];
  assign wb_rd_o    = fifo_rd_q[rd_ptr_q];
  assign wb_tag_o   = fifo_tag_q[rd_ptr_q];

  assign used_d  = used_q + CNT_W'(issue) - CNT_W'(pop);
  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  assign idle_o = (used_q == '0);
  assign err_o  = err_q;

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      used_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < MUL_LAT; i++) sh_v_q[i] <= 1'b0;
    end else begin
      used_q    <= used_d;
      count_q   <= count_d;
      sh_v_q[0] <= issue;
      for (int i = 1; i < MUL_LAT; i++) sh_v_q[i] <= sh_v_q[i-1];
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  // Metadata and FIFO payload carry no reset; the valids above qualify them.
  always_ff @(posedge clk) begin
    sh_rd_q[0]  <= req_rd_i;
    sh_tag_q[0] <= req_tag_i;
    for (int i = 1; i < MUL_LAT; i++) begin
      sh_rd_q[i]  <= sh_rd_q[i-1];
      sh_tag_q[i] <= sh_tag_q[i-1];
    end
    if (push) begin
      fifo_data_q[wr_ptr_q] <= mul_res_i;
      fifo_rd_q[wr_ptr_q]   <= sh_rd_q[LAST];
      fifo_tag_q[wr_ptr_q]  <= sh_tag_q[LAST];
    end
  end

  // The multiplier still delivers its stage-4 op right after a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q        <= 1'b0;
      flush_mask_q <= 1'b0;
    end else begin
      flush_mask_q <= flush_i;
      if (!flush_mask_q && (mul_valid_i != sh_v_q[LAST])) err_q <= 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      fifo_live[i] = ((i - int'(rd_ptr_q) + DEPTH) % DEPTH) < int'(count_q);
    end
  end

  always_comb begin
    hazard_o = 1'b0;
    for (int i = 0; i < MUL_LAT; i++) begin
      if (sh_v_q[i] && rd_hit(sh_rd_q[i], rs1_i, rs2_i)) hazard_o = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (fifo_live[i] && rd_hit(fifo_rd_q[i], rs1_i, rs2_i)) hazard_o = 1'b1;
    end
  end
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: per-cycle vector table plus hand-written
// reset/error sequences, driven against a behavioural 5-stage multiplier.
module tb_mul_issue_ctrl;
  localparam int TAG_W = 6;
  localparam logic [3:0] OP_MUL    = 4'd0;
  localparam logic [3:0] OP_MULH   = 4'd1;
  localparam logic [3:0] OP_MULHSU = 4'd2;
  localparam logic [3:0] OP_MULHU  = 4'd3;
  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic clk = 1'b0;
  logic reset;
  logic req_valid_i, req_ready_o, req_word_i, flush_i;
  logic [63:0] req_opr_a_i, req_opr_b_i;
  logic [3:0] req_func_i;
  logic [4:0] req_rd_i;
  logic [TAG_W-1:0] req_tag_i;
  logic [63:0] mul_opr_a_o, mul_opr_b_o, mul_res_i;
  logic mul_instr_o, mul_word_o, mul_kill_o, mul_flush_o, mul_valid_i;
  logic [3:0] mul_func_o;
  logic wb_valid_o, wb_ready_i;
  logic [63:0] wb_data_o;
  logic [4:0] wb_rd_o, rs1_i, rs2_i;
  logic [TAG_W-1:0] wb_tag_o;
  logic hazard_o, idle_o, err_o;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.DEPTH(4), .TAG_W(TAG_W), .MUL_LAT(5)) dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_opr_a_i(req_opr_a_i), .req_opr_b_i(req_opr_b_i),
    .req_func_i(req_func_i), .req_word_i(req_word_i),
    .req_rd_i(req_rd_i), .req_tag_i(req_tag_i), .flush_i(flush_i),
    .mul_opr_a_o(mul_opr_a_o), .mul_opr_b_o(mul_opr_b_o),
    .mul_instr_o(mul_instr_o), .mul_func_o(mul_func_o),
    .mul_word_o(mul_word_o), .mul_kill_o(mul_kill_o), .mul_flush_o(mul_flush_o),
    .mul_res_i(mul_res_i), .mul_valid_i(mul_valid_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_tag_o(wb_tag_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .hazard_o(hazard_o),
    .idle_o(idle_o), .err_o(err_o)
  );

  // Behavioural multiplier: 5 stages, kill keeps only the stage-4 op.
  logic        m_v [5];
  logic [63:0] m_d [5];
  logic        force_v = 1'b0;
  assign mul_valid_i = m_v[4] | force_v;
  assign mul_res_i   = m_d[4];

  function automatic logic [63:0] mul_ref(input logic [63:0] a, input logic [63:0] b,
                                          input logic [3:0] f, input logic w);
    logic [127:0] p;
    case (f)
      OP_MULH:   p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
      OP_MULHSU: p = {{64{a[63]}}, a} * {64'd0, b};
      OP_MULHU:  p = {64'd0, a} * {64'd0, b};
      default:   p = {64'd0, a} * {64'd0, b};
    endcase
    if (f == OP_MUL) return w ? {{32{p[31]}}, p[31:0]} : p[63:0];
    return p[127:64];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) m_v[i] <= 1'b0;
    end else if (mul_kill_o || mul_flush_o) begin
      for (int i = 0; i < 4; i++) m_v[i] <= 1'b0;
      m_v[4] <= m_v[3];
    end else begin
      m_v[0] <= mul_instr_o;
      for (int i = 1; i < 5; i++) m_v[i] <= m_v[i-1];
    end
    m_d[0] <= mul_ref(mul_opr_a_o, mul_opr_b_o, mul_func_o, mul_word_o);
    for (int i = 1; i < 5; i++) m_d[i] <= m_d[i-1];
  end

  typedef struct {
    logic req_v; logic [63:0] a; logic [63:0] b; logic [3:0] func; logic word;
    logic [4:0] rd; logic [TAG_W-1:0] tag; logic flush; logic wb_rdy;
    logic [4:0] rs1; logic [4:0] rs2; logic rst; logic frc;
    logic e_rdy; logic e_wbv; logic e_haz; logic e_idle; logic e_err;
    logic e_chk; logic [63:0] e_data; logic [4:0] e_rd; logic [TAG_W-1:0] e_tag;
  } vec_t;

  int n_applied = 0;
  int n_checks  = 0;
  int n_fail    = 0;
  vec_t tbl[$];

  function automatic vec_t nv(input logic wr, input logic [4:0] r1, input logic [4:0] r2,
                              input logic rdy, input logic wbv, input logic haz,
                              input logic idl);
    vec_t t;
    t = '{req_v: 1'b0, a: 64'd0, b: 64'd0, func: OP_MUL, word: 1'b0, rd: 5'd0,
          tag: '0, flush: 1'b0, wb_rdy: wr, rs1: r1, rs2: r2, rst: 1'b0, frc: 1'b0,
          e_rdy: rdy, e_wbv: wbv, e_haz: haz, e_idle: idl, e_err: 1'b0,
          e_chk: 1'b0, e_data: 64'd0, e_rd: 5'd0, e_tag: '0};
    return t;
  endfunction

  function automatic vec_t rq(input vec_t t, input logic [63:0] a, input logic [63:0] b,
                              input logic [3:0] f, input logic w, input logic [4:0] rd,
                              input logic [TAG_W-1:0] tag);
    t.req_v = 1'b1; t.a = a; t.b = b; t.func = f; t.word = w; t.rd = rd; t.tag = tag;
    return t;
  endfunction

  function automatic vec_t wb(input vec_t t, input logic [63:0] d, input logic [4:0] rd,
                              input logic [TAG_W-1:0] tag);
    t.e_chk = 1'b1; t.e_data = d; t.e_rd = rd; t.e_tag = tag;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vector %0d): got %h, expected %h", name, n_applied, act, exp);
    end
  endtask

  task automatic apply(input vec_t t);
    @(posedge clk);
    #1;
    reset = t.rst; force_v = t.frc; flush_i = t.flush; wb_ready_i = t.wb_rdy;
    req_valid_i = t.req_v; req_opr_a_i = t.a; req_opr_b_i = t.b;
    req_func_i = t.func; req_word_i = t.word; req_rd_i = t.rd; req_tag_i = t.tag;
    rs1_i = t.rs1; rs2_i = t.rs2;
    #4;
    chk("req_ready", 64'(req_ready_o), 64'(t.e_rdy));
    chk("mul_instr", 64'(mul_instr_o), 64'(t.req_v & t.e_rdy));
    chk("mul_kill",  64'(mul_kill_o),  64'(t.flush));
    chk("mul_flush", 64'(mul_flush_o), 64'(t.flush));
    chk("wb_valid",  64'(wb_valid_o),  64'(t.e_wbv));
    chk("hazard",    64'(hazard_o),    64'(t.e_haz));
    chk("idle",      64'(idle_o),      64'(t.e_idle));
    chk("err",       64'(err_o),       64'(t.e_err));
    if (t.req_v) begin
      chk("opr_a", mul_opr_a_o, t.a);
      chk("opr_b", mul_opr_b_o, t.b);
    end
    if (t.e_chk) begin
      chk("wb_data", wb_data_o, t.e_data);
      chk("wb_rd",   64'(wb_rd_o),  64'(t.e_rd));
      chk("wb_tag",  64'(wb_tag_o), 64'(t.e_tag));
    end
    n_applied++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    reset = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b0; req_valid_i = 1'b0;
    req_opr_a_i = '0; req_opr_b_i = '0; req_func_i = '0; req_word_i = 1'b0;
    req_rd_i = '0; req_tag_i = '0; rs1_i = 5'd1; rs2_i = 5'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #4;
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_wbv",   64'(wb_valid_o),  64'd0);
    chk("rst_haz",   64'(hazard_o),    64'd0);
    chk("rst_idle",  64'(idle_o),      64'd1);
    chk("rst_err",   64'(err_o),       64'd0);

    // Single MUL: 3 * -5, rd 7, tag 2; result at cycle 6.
    tbl.push_back(rq(nv(1, 7, 0, 1, 0, 0, 1), 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, OP_MUL, 0, 7, 2));
    for (int i = 1; i <= 5; i++) tbl.push_back(nv(1, 7, 0, 1, 0, 1, 0));
    tbl.push_back(wb(nv(1, 7, 0, 1, 1, 1, 0), 64'hFFFF_FFFF_FFFF_FFF1, 7, 2));
    tbl.push_back(nv(1, 7, 0, 1, 0, 0, 1));

    // Back-to-back 4 ops with writeback stalled, drained from cycle 10.
    for (int i = 0; i < 4; i++)
      tbl.push_back(rq(nv(0, 4, 0, 1, 0, 0, i == 0), 64'(i + 1), 64'd10, OP_MUL, 0,
                       5'(i + 1), TAG_W'(i)));
    tbl.push_back(nv(0, 4, 0, 0, 0, 1, 0));
    tbl.push_back(nv(0, 4, 0, 0, 0, 1, 0));
    for (int i = 6; i <= 9; i++) tbl.push_back(wb(nv(0, 4, 0, 0, 1, 1, 0), 64'd10, 1, 0));
    tbl.push_back(wb(nv(1, 4, 0, 0, 1, 1, 0), 64'd10, 1, 0));
    tbl.push_back(wb(nv(1, 4, 0, 1, 1, 1, 0), 64'd20, 2, 1));
    tbl.push_back(wb(nv(1, 4, 0, 1, 1, 1, 0), 64'd30, 3, 2));
    tbl.push_back(wb(nv(1, 4, 0, 1, 1, 1, 0), 64'd40, 4, 3));
    tbl.push_back(nv(1, 4, 0, 1, 0, 0, 1));

    // Same-cycle push/pop (plus an issue) with one entry buffered.
    tbl.push_back(rq(nv(0, 0, 9, 1, 0, 0, 1), 64'd2, 64'd3, OP_MUL, 0, 9, 5));
    tbl.push_back(rq(nv(0, 0, 9, 1, 0, 1, 0), ALL1, ALL1, OP_MUL, 0, 10, 6));
    for (int i = 2; i <= 5; i++) tbl.push_back(nv(0, 0, 9, 1, 0, 1, 0));
    tbl.push_back(rq(wb(nv(1, 0, 9, 1, 1, 1, 0), 64'd6, 9, 5),
                     64'h8000_0000_0000_0000, 64'd4, OP_MULHU, 0, 11, 7));
    tbl.push_back(wb(nv(1, 0, 9, 1, 1, 0, 0), 64'd1, 10, 6));
    for (int i = 8; i <= 11; i++) tbl.push_back(nv(1, 0, 9, 1, 0, 0, 0));
    tbl.push_back(wb(nv(1, 0, 9, 1, 1, 0, 0), 64'd2, 11, 7));
    tbl.push_back(nv(1, 0, 9, 1, 0, 0, 1));

    // Flush mid-flight, with a request presented in the flush cycle.
    for (int i = 0; i < 4; i++)
      tbl.push_back(rq(nv(1, 12, 0, 1, 0, i != 0, i == 0), 64'd5, 64'd5, OP_MUL, 0,
                       5'(12 + i), TAG_W'(8 + i)));
    t = rq(nv(1, 12, 0, 0, 0, 1, 0), 64'd9, 64'd9, OP_MUL, 0, 16, 12);
    t.flush = 1'b1;
    tbl.push_back(t);
    for (int i = 5; i <= 10; i++) tbl.push_back(nv(1, 12, 0, 1, 0, 0, 1));

    // MULW with rd = x0: no hazard despite rs1 = rs2 = 0.
    tbl.push_back(rq(nv(1, 0, 0, 1, 0, 0, 1), 64'h1_0000_0003, 64'd5, OP_MUL, 1, 0, 13));
    for (int i = 1; i <= 5; i++) tbl.push_back(nv(1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(wb(nv(1, 0, 0, 1, 1, 0, 0), 64'd15, 0, 13));
    tbl.push_back(nv(1, 0, 0, 1, 0, 0, 1));

    // Signed MULH: -2 * 3 high half is all ones.
    tbl.push_back(rq(nv(1, 0, 0, 1, 0, 0, 1), 64'hFFFF_FFFF_FFFF_FFFE, 64'd3, OP_MULH, 0, 20, 14));
    for (int i = 1; i <= 5; i++) tbl.push_back(nv(1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(wb(nv(1, 0, 0, 1, 1, 0, 0), ALL1, 20, 14));
    tbl.push_back(nv(1, 0, 0, 1, 0, 0, 1));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // Reset while an op is in flight: nothing is written back afterwards.
    apply(rq(nv(1, 3, 0, 1, 0, 0, 1), 64'd7, 64'd7, OP_MUL, 0, 3, 20));
    apply(nv(1, 3, 0, 1, 0, 1, 0));
    t = nv(1, 3, 0, 1, 0, 1, 0);
    t.rst = 1'b1;
    apply(t);
    for (int i = 3; i <= 9; i++) apply(nv(1, 3, 0, 1, 0, 0, 1));

    // Spurious mul_valid_i: err_o sets, stays sticky, and only reset clears it.
    t = nv(1, 0, 0, 1, 0, 0, 1);
    t.frc = 1'b1;
    apply(t);
    for (int i = 1; i <= 4; i++) begin
      t = nv(1, 0, 0, 1, 0, 0, 1);
      t.e_err = 1'b1;
      apply(t);
    end
    t = nv(1, 0, 0, 1, 0, 0, 1);
    t.e_err = 1'b1;
    t.rst = 1'b1;
    apply(t);
    apply(nv(1, 0, 0, 1, 0, 0, 1));

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_fail);
    $finish;
  end
endmodule
